// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, scan-phase encoding, RGB444 pixel type and test-bar colour helper.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Bar index bits {2,1,0} map to {R,G,B}: bar 0 is black, bar 7 is white.
  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    rgb444_t c;
    c.r = idx[2] ? 4'hF : 4'h0;
    c.g = idx[1] ? 4'hF : 4'h0;
    c.b = idx[0] ? 4'hF : 4'h0;
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: count 0..total-1 plus ACTIVE/FRONT/SYNC/BACK phase, stepping only when adv is high.
// count/phase are registered; wrap is combinational and marks the total-1 -> 0 step; no backpressure.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = 640,
  parameter int FRONT_LEN  = 16,
  parameter int SYNC_LEN   = 96,
  parameter int BACK_LEN   = 48,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

  logic [W-1:0] ph_cnt;
  logic [W-1:0] ph_cnt_nxt;
  logic [W-1:0] count_nxt;
  logic [W-1:0] ph_last;
  phase_t       phase_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      ph_cnt <= '0;
      phase  <= ACTIVE;
    end else begin
      count  <= count_nxt;
      ph_cnt <= ph_cnt_nxt;
      phase  <= phase_nxt;
    end
  end

  always_comb begin
    ph_last    = W'(ACTIVE_LEN - 1);
    count_nxt  = count;
    ph_cnt_nxt = ph_cnt;
    phase_nxt  = phase;
    case (phase)
      ACTIVE:  ph_last = W'(ACTIVE_LEN - 1);
      FRONT:   ph_last = W'(FRONT_LEN - 1);
      SYNC:    ph_last = W'(SYNC_LEN - 1);
      default: ph_last = W'(BACK_LEN - 1);
    endcase
    wrap = adv && (count == W'(TOTAL - 1));
    if (adv) begin
      count_nxt = wrap ? '0 : count + 1'b1;
      if (ph_cnt == ph_last) begin
        ph_cnt_nxt = '0;
        case (phase)
          ACTIVE:  phase_nxt = FRONT;
          FRONT:   phase_nxt = SYNC;
          SYNC:    phase_nxt = BACK;
          default: phase_nxt = ACTIVE;
        endcase
      end else begin
        ph_cnt_nxt = ph_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: col/row and frame pulses at zero latency, vga_* outputs RENDER_LAT+1 cycles later, no backpressure.
// Macro VGA_TEST_PATTERN_EN: when defined, test_mode=1 swaps renderer colours for eight 80-pixel colour bars.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int RENDER_LAT = 1,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic       pixel_clk,
  input  logic       resetSwitch,
  output logic [9:0] col,
  output logic [8:0] row,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  input  logic       test_mode,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_de,
  output logic       frame_start,
  output logic       frame_end
);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] col;
`endif
  } tap_t;

  logic [9:0] h_count;
  logic [9:0] v_count;
  phase_t     h_phase;
  phase_t     v_phase;
  logic       h_wrap;
  logic       unused_v_wrap;
  tap_t       tap_raw;
  tap_t       tap_dly;
  rgb444_t    pix;
  rgb444_t    rgb_q;

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FP), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BP), .W(10)
  ) u_h_axis (
    .clk(pixel_clk), .rst(resetSwitch), .adv(1'b1),
    .count(h_count), .phase(h_phase), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FP), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BP), .W(10)
  ) u_v_axis (
    .clk(pixel_clk), .rst(resetSwitch), .adv(h_wrap),
    .count(v_count), .phase(v_phase), .wrap(unused_v_wrap)
  );

  assign col = (h_phase == ACTIVE) ? h_count : '0;
  assign row = (v_phase == ACTIVE) ? v_count[8:0] : '0;

  // Gated by reset so the pulses stay low while the counters are held at zero.
  assign frame_start = !resetSwitch && (h_count == '0) && (v_count == '0);
  assign frame_end   = !resetSwitch && (h_count == '0) && (v_count == 10'(V_ACTIVE));

  always_comb begin
    tap_raw    = '0;
    tap_raw.hs = (h_phase == SYNC);
    tap_raw.vs = (v_phase == SYNC);
    tap_raw.de = (h_phase == ACTIVE) && (v_phase == ACTIVE);
`ifdef VGA_TEST_PATTERN_EN
    tap_raw.col = col;
`endif
  end

  generate
    if (RENDER_LAT == 0) begin : g_lat0
      assign tap_dly = tap_raw;
    end else begin : g_latn
      tap_t pipe [RENDER_LAT];
      always_ff @(posedge pixel_clk) begin
        if (resetSwitch) begin
          for (int i = 0; i < RENDER_LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= tap_raw;
          for (int i = 1; i < RENDER_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign tap_dly = pipe[RENDER_LAT-1];
    end
  endgenerate

  // Renderer colour arrives now for the coordinates carried by tap_dly.
  always_comb begin
    pix = '0;
    if (tap_dly.de) begin
      pix = {red_in, green_in, blue_in};
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) pix = bar_colour(3'(tap_dly.col / 10'd80));
`endif
    end
  end

`ifndef VGA_TEST_PATTERN_EN
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  always_ff @(posedge pixel_clk) begin
    if (resetSwitch) begin
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
      vga_de <= 1'b0;
      rgb_q  <= '0;
    end else begin
      vga_hs <= tap_dly.hs ? SYNC_POL : ~SYNC_POL;
      vga_vs <= tap_dly.vs ? SYNC_POL : ~SYNC_POL;
      vga_de <= tap_dly.de;
      rgb_q  <= pix;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen: reduced vertical geometry, RENDER_LAT=2, arithmetic scan model.
module tb_vga_scan_gen;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 12, VF = 3, VS = 2, VB = 3;
  localparam int LAT = 2;
  localparam bit SP = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic       pixel_clk;
  logic       resetSwitch;
  logic [9:0] col;
  logic [8:0] row;
  logic [3:0] red_in, green_in, blue_in;
  logic       test_mode;
  logic       vga_hs, vga_vs, vga_de;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       frame_start, frame_end;

  vga_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .RENDER_LAT(LAT), .SYNC_POL(SP)
  ) dut (
    .pixel_clk(pixel_clk), .resetSwitch(resetSwitch),
    .col(col), .row(row),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .test_mode(test_mode),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_de(vga_de), .frame_start(frame_start), .frame_end(frame_end)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int col; int row; bit fs; bit fe;
    bit hs; bit vs; bit de; logic [11:0] rgb;
    int h; int v;
  } exp_t;

  int errors = 0;
  int checks = 0;
  int n = 0;
  bit rst_prev = 1'b0;
  int mode = 0;        // 0 renderer function, 1 constant white, 2 random
  int drv_mode = 0;
  int prev_mode = 0;
  bit tm_want = 1'b0;
  bit prev_tm = 1'b0;
  logic [11:0] drv = '0;
  logic [11:0] prev_drv = '0;
  logic [3:0] key;
  logic [18:0] hist [$];
  exp_t ex;

  function automatic logic [11:0] render(input int c, input int r);
    logic [3:0] cr, rr, hi;
    cr = 4'(c);
    rr = 4'(r);
    hi = 4'(c >> 4) ^ key;
    return {cr, rr, hi};
  endfunction

  function automatic logic [11:0] bar(input int c);
    int idx;
    idx = c / 80;
    return {idx[2] ? 4'hF : 4'h0, idx[1] ? 4'hF : 4'h0, idx[0] ? 4'hF : 4'h0};
  endfunction

  // Position of cycle k since reset release is (k mod HT, k div HT mod VT);
  // display outputs describe the position LAT+1 cycles earlier.
  function automatic exp_t model(input bit rst);
    exp_t e;
    int m, mh, mv;
    e = '{default: 0};
    e.hs = ~SP;
    e.vs = ~SP;
    e.rgb = '0;
    if (!rst) begin
      e.h = n % HT;
      e.v = (n / HT) % VT;
      e.col = (e.h < HA) ? e.h : 0;
      e.row = (e.v < VA) ? e.v : 0;
      e.fs = (e.h == 0) && (e.v == 0);
      e.fe = (e.h == 0) && (e.v == VA);
      m = n - LAT - 1;
      if (m >= 0) begin
        mh = m % HT;
        mv = (m / HT) % VT;
        e.hs = (mh >= HA + HF && mh < HA + HF + HS) ? SP : ~SP;
        e.vs = (mv >= VA + VF && mv < VA + VF + VS) ? SP : ~SP;
        e.de = (mh < HA) && (mv < VA);
        if (e.de) begin
          if (TP && prev_tm) e.rgb = bar(mh);
          else if (prev_mode == 0) e.rgb = render(mh, mv);
          else e.rgb = prev_drv;
        end
      end
    end
    return e;
  endfunction

  task automatic cycle(input bit rst);
    logic [18:0] ent;
    bit have;
    @(posedge pixel_clk);
    #1;
    if (rst_prev) begin
      n = 0;
      hist.delete();
    end else begin
      n++;
    end
    prev_drv = drv;
    prev_mode = drv_mode;
    prev_tm = test_mode;
    resetSwitch = rst;
    test_mode = tm_want;
    drv_mode = mode;
    have = (hist.size() == LAT);
    ent = '0;
    if (have) ent = hist.pop_front();
    if (mode == 1) drv = 12'hFFF;
    else if (mode == 2 || !have || rst) drv = 12'($urandom);
    else drv = render(int'(ent[18:9]), int'(ent[8:0]));
    {red_in, green_in, blue_in} = drv;
    @(negedge pixel_clk);
    if (!rst) hist.push_back({col, row});
    ex = model(rst);
    rst_prev = rst;
  endtask

  task automatic test_reset();
    mode = 0;
    tm_want = 1'b0;
    cycle(1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1);
      if ({col, row, frame_start, frame_end} !== {10'(ex.col), 9'(ex.row), ex.fs, ex.fe}) begin
        errors++;
        $display("FAIL reset_coord got=%h exp=%h", {col, row, frame_start, frame_end}, {10'(ex.col), 9'(ex.row), ex.fs, ex.fe});
      end
      checks++;
      if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b} !== {ex.hs, ex.vs, ex.de, ex.rgb}) begin
        errors++;
        $display("FAIL reset_out got=%h exp=%h", {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}, {ex.hs, ex.vs, ex.de, ex.rgb});
      end
      checks++;
    end
    cycle(1'b0);
    if ({col, row, frame_start, frame_end} !== {10'(ex.col), 9'(ex.row), ex.fs, ex.fe}) begin
      errors++;
      $display("FAIL release_coord got=%h exp=%h", {col, row, frame_start, frame_end}, {10'(ex.col), 9'(ex.row), ex.fs, ex.fe});
    end
    checks++;
    if ({vga_hs, vga_vs, vga_de} !== {ex.hs, ex.vs, ex.de}) begin
      errors++;
      $display("FAIL release_sync got=%b exp=%b", {vga_hs, vga_vs, vga_de}, {ex.hs, ex.vs, ex.de});
    end
    checks++;
  endtask

  task automatic test_line();
    int hcnt, hfirst, dcnt;
    hcnt = 0; hfirst = -1; dcnt = 0;
    for (int i = 0; i < HT; i++) begin
      cycle(1'b0);
      if ({col, row, frame_start, frame_end} !== {10'(ex.col), 9'(ex.row), ex.fs, ex.fe}) begin
        errors++;
        $display("FAIL line_coord n=%0d got=%h exp=%h", n, {col, row, frame_start, frame_end}, {10'(ex.col), 9'(ex.row), ex.fs, ex.fe});
      end
      checks++;
      if ({vga_hs, vga_vs, vga_de} !== {ex.hs, ex.vs, ex.de}) begin
        errors++;
        $display("FAIL line_sync n=%0d got=%b exp=%b", n, {vga_hs, vga_vs, vga_de}, {ex.hs, ex.vs, ex.de});
      end
      checks++;
      if (vga_hs == SP) begin
        if (hcnt == 0) hfirst = n;
        hcnt++;
      end
      if (vga_de) dcnt++;
    end
    if (hcnt != HS || hfirst != HA + HF + LAT + 1) begin
      errors++;
      $display("FAIL hsync_window got=%0d@%0d exp=%0d@%0d", hcnt, hfirst, HS, HA + HF + LAT + 1);
    end
    checks++;
    if (dcnt != HA) begin
      errors++;
      $display("FAIL de_per_line got=%0d exp=%0d", dcnt, HA);
    end
    checks++;
  endtask

  task automatic test_frame();
    int vfirst, vlast, fe_n, fs_n;
    bit seen;
    vfirst = -1; vlast = -1; fe_n = -1; fs_n = -1; seen = 1'b0;
    mode = 0;
    for (int i = 0; i < FT + 10 && !seen; i++) begin
      cycle(1'b0);
      if ({col, row, frame_start, frame_end} !== {10'(ex.col), 9'(ex.row), ex.fs, ex.fe}) begin
        errors++;
        $display("FAIL frame_coord n=%0d got=%h exp=%h", n, {col, row, frame_start, frame_end}, {10'(ex.col), 9'(ex.row), ex.fs, ex.fe});
      end
      checks++;
      if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b} !== {ex.hs, ex.vs, ex.de, ex.rgb}) begin
        errors++;
        $display("FAIL frame_out n=%0d got=%h exp=%h", n, {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}, {ex.hs, ex.vs, ex.de, ex.rgb});
      end
      checks++;
      if (vga_vs == SP) begin
        if (vfirst < 0) vfirst = n;
        vlast = n;
      end
      if (frame_end) fe_n = n;
      if (frame_start) begin
        seen = 1'b1;
        fs_n = n;
      end
    end
    if (!seen || fs_n != FT) begin
      errors++;
      $display("FAIL frame_period got=%0d exp=%0d", fs_n, FT);
    end
    checks++;
    if (vfirst != (VA + VF) * HT + LAT + 1 || vlast != (VA + VF + VS) * HT + LAT) begin
      errors++;
      $display("FAIL vsync_window got=%0d..%0d exp=%0d..%0d", vfirst, vlast, (VA + VF) * HT + LAT + 1, (VA + VF + VS) * HT + LAT);
    end
    checks++;
    if (fe_n != VA * HT) begin
      errors++;
      $display("FAIL frame_end_pos got=%0d exp=%0d", fe_n, VA * HT);
    end
    checks++;
  endtask

  task automatic test_colour(input int m, input int cycles, input bit tm);
    mode = m;
    tm_want = tm;
    for (int i = 0; i < cycles; i++) begin
      cycle(1'b0);
      if ({vga_de, vga_r, vga_g, vga_b} !== {ex.de, ex.rgb}) begin
        errors++;
        $display("FAIL colour_m%0d_t%0d n=%0d got=%h exp=%h", m, tm, n, {vga_de, vga_r, vga_g, vga_b}, {ex.de, ex.rgb});
      end
      checks++;
      if ({col, row} !== {10'(ex.col), 9'(ex.row)}) begin
        errors++;
        $display("FAIL colour_coord n=%0d got=%h exp=%h", n, {col, row}, {10'(ex.col), 9'(ex.row)});
      end
      checks++;
    end
    tm_want = 1'b0;
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    mode = 1;
    while ((((n + 1) % HT) != 700 || (((n + 1) / HT) % VT) != VA + VF) && guard < FT + HT) begin
      cycle(1'b0);
      guard++;
      if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b} !== {ex.hs, ex.vs, ex.de, ex.rgb}) begin
        errors++;
        $display("FAIL approach_out n=%0d got=%h exp=%h", n, {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}, {ex.hs, ex.vs, ex.de, ex.rgb});
      end
      checks++;
    end
    if (guard >= FT + HT) begin
      errors++;
      $display("FAIL approach_timeout got=%0d exp<%0d", guard, FT + HT);
    end
    checks++;
    cycle(1'b1);
    if ({vga_hs, vga_vs} !== {SP, SP}) begin
      errors++;
      $display("FAIL pre_reset_sync got=%b exp=%b", {vga_hs, vga_vs}, {SP, SP});
    end
    checks++;
    for (int i = 0; i < LAT + 4; i++) begin
      cycle(1'b0);
      if ({col, row, frame_start, frame_end} !== {10'(ex.col), 9'(ex.row), ex.fs, ex.fe}) begin
        errors++;
        $display("FAIL midrst_coord n=%0d got=%h exp=%h", n, {col, row, frame_start, frame_end}, {10'(ex.col), 9'(ex.row), ex.fs, ex.fe});
      end
      checks++;
      if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b} !== {ex.hs, ex.vs, ex.de, ex.rgb}) begin
        errors++;
        $display("FAIL midrst_out n=%0d got=%h exp=%h", n, {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}, {ex.hs, ex.vs, ex.de, ex.rgb});
      end
      checks++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout n=%0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    resetSwitch = 1'b1;
    test_mode = 1'b0;
    {red_in, green_in, blue_in} = '0;
    key = 4'($urandom);
    test_reset();
    test_line();
    test_frame();
    test_colour(1, 2 * HT, 1'b0);
    test_colour(2, HT, 1'b0);
    test_colour(0, HT, 1'b0);
    test_mid_reset();
    test_colour(0, HT, 1'b1);
    test_colour(0, HT, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
